coef_bank: RTL and testbench

COEF_BANK -- requirements
Module: coef_bank

---
 rtl/coef_bank.sv | 152 +++++++++++++++
 tb/tb_coef_bank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/coef_bank.sv
// coef_bank: adaptive-filter coefficient store, N bins x 4 signed components
// (W0 re/im, W1 re/im). Per-bin LMS-style update new = sat(old - (G >>> MU_SHIFT))
// with a one-cycle registered read port and a zeroing sweep (CLEAR) after reset
// or on i_clear.
//
// Ports:
//   clk, rst (sync, active low)
//   i_rd_en, i_k_idx             -> o_W*_re/im, o_rd_valid (1-cycle latency)
//   i_upd_valid, i_upd_k, i_G*   -> gradient update, o_upd_drop when discarded
//   i_clear                      -> restart zeroing sweep, o_busy while sweeping

// One component array: storage, saturating update datapath and read register.
module coef_lane #(
  parameter int W        = 16,
  parameter int N        = 32,
  parameter int MU_SHIFT = 4,
  parameter int IW       = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_we,
  input  logic [IW-1:0]        clr_idx,
  input  logic                 upd_we,
  input  logic [IW-1:0]        upd_idx,
  input  logic signed [W-1:0]  grad,
  input  logic                 rd_en,
  input  logic [IW-1:0]        rd_idx,
  output logic signed [W-1:0]  rd_data
);
  logic signed [W-1:0] mem [N];
  logic signed [W-1:0] old, g_sh, sat;
  logic signed [W:0]   diff;

  assign old  = mem[upd_idx];
  assign g_sh = grad >>> MU_SHIFT;
  // One guard bit is enough: difference of two W-bit values fits in W+1.
  assign diff = {old[W-1], old} - {g_sh[W-1], g_sh};

  always_comb begin
    sat = diff[W-1:0];
    if (diff[W] != diff[W-1])
      sat = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  // Sweep and update never overlap (CLEAR vs RUN), so a single write port suffices.
  always_ff @(posedge clk) begin
    if (clr_we)      mem[clr_idx] <= '0;
    else if (upd_we) mem[upd_idx] <= sat;
  end

  // Read samples the array before this edge's write lands: read-before-write.
  always_ff @(posedge clk) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end
endmodule

module coef_bank #(
  parameter int W        = 16,
  parameter int N        = 32,
  parameter int MU_SHIFT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_rd_en,
  input  logic [4:0]          i_k_idx,
  output logic signed [W-1:0] o_W0_re,
  output logic signed [W-1:0] o_W0_im,
  output logic signed [W-1:0] o_W1_re,
  output logic signed [W-1:0] o_W1_im,
  output logic                o_rd_valid,
  input  logic                i_upd_valid,
  input  logic [4:0]          i_upd_k,
  input  logic signed [W-1:0] i_G0_re,
  input  logic signed [W-1:0] i_G0_im,
  input  logic signed [W-1:0] i_G1_re,
  input  logic signed [W-1:0] i_G1_im,
  input  logic                i_clear,
  output logic                o_busy,
  output logic                o_upd_drop
);
  localparam int NUM_LANES = 4;
  localparam int IW        = 5;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          clr_we, upd_we, rd_acc;

  logic [NUM_LANES-1:0][W-1:0] grad;
  logic [NUM_LANES-1:0][W-1:0] rd_w;

  assign grad = {i_G1_im, i_G1_re, i_G0_im, i_G0_re};

  // i_clear outranks everything: it blocks the sweep write, reads and updates.
  assign clr_we = rst && (state_q == CLEAR) && !i_clear;
  assign upd_we = rst && (state_q == RUN) && i_upd_valid && !i_clear;
  assign rd_acc = rst && (state_q == RUN) && i_rd_en && !i_clear;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_clear) begin
      state_d = CLEAR;
      cnt_d   = '0;
    end else if (state_q == CLEAR) begin
      if (cnt_q == IW'(N-1)) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      o_rd_valid <= 1'b0;
      o_upd_drop <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      o_rd_valid <= rd_acc;
      o_upd_drop <= i_upd_valid && ((state_q == CLEAR) || i_clear);
    end
  end

  assign o_busy = (state_q == CLEAR);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    coef_lane #(.W(W), .N(N), .MU_SHIFT(MU_SHIFT), .IW(IW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr_we  (clr_we),
      .clr_idx (cnt_q),
      .upd_we  (upd_we),
      .upd_idx (i_upd_k),
      .grad    (grad[l]),
      .rd_en   (rd_acc),
      .rd_idx  (i_k_idx),
      .rd_data (rd_w[l])
    );
  end

  assign o_W0_re = rd_w[0];
  assign o_W0_im = rd_w[1];
  assign o_W1_re = rd_w[2];
  assign o_W1_im = rd_w[3];
endmodule

// File: tb/tb_coef_bank.sv
// Directed bench for coef_bank: an abstract model (sweep-remaining counter plus
// plain integer arrays) is stepped at each rising edge and compared against the
// DUT on every falling edge; literal checks pin the model on key scenarios.
module tb_coef_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b0;
  logic               i_rd_en = 1'b0, i_upd_valid = 1'b0, i_clear = 1'b0;
  logic [4:0]         i_k_idx = '0, i_upd_k = '0;
  logic signed [15:0] i_G0_re = '0, i_G0_im = '0, i_G1_re = '0, i_G1_im = '0;
  logic signed [15:0] o_W0_re, o_W0_im, o_W1_re, o_W1_im;
  logic               o_rd_valid, o_busy, o_upd_drop;

  coef_bank dut (
    .clk(clk), .rst(rst),
    .i_rd_en(i_rd_en), .i_k_idx(i_k_idx),
    .o_W0_re(o_W0_re), .o_W0_im(o_W0_im), .o_W1_re(o_W1_re), .o_W1_im(o_W1_im),
    .o_rd_valid(o_rd_valid),
    .i_upd_valid(i_upd_valid), .i_upd_k(i_upd_k),
    .i_G0_re(i_G0_re), .i_G0_im(i_G0_im), .i_G1_re(i_G1_re), .i_G1_im(i_G1_im),
    .i_clear(i_clear), .o_busy(o_busy), .o_upd_drop(o_upd_drop)
  );

  int tests = 0, fails = 0;
  bit chk_en = 1'b0;

  // Model state
  int m [4][32];
  int e_w [4];
  int left = 32;
  bit e_val = 1'b0, e_drop = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat16(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_edge();
    int gv [4];
    bit run;
    gv[0] = int'(i_G0_re); gv[1] = int'(i_G0_im);
    gv[2] = int'(i_G1_re); gv[3] = int'(i_G1_im);
    if (!rst) begin
      left = 32; e_val = 0; e_drop = 0;
      for (int j = 0; j < 4; j++) begin
        e_w[j] = 0;
        for (int k = 0; k < 32; k++) m[j][k] = 0;
      end
    end else begin
      run    = (left == 0);
      e_drop = i_upd_valid && (!run || i_clear);
      if (i_clear) begin
        left = 32; e_val = 0;
        for (int j = 0; j < 4; j++)
          for (int k = 0; k < 32; k++) m[j][k] = 0;
      end else begin
        e_val = i_rd_en && run;
        if (e_val)
          for (int j = 0; j < 4; j++) e_w[j] = m[j][i_k_idx];
        if (!run) left--;
        else if (i_upd_valid)
          for (int j = 0; j < 4; j++)
            m[j][i_upd_k] = sat16(m[j][i_upd_k] - (gv[j] >>> 4));
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",     int'(o_busy),     int'(left != 0));
      chk("rd_valid", int'(o_rd_valid), int'(e_val));
      chk("upd_drop", int'(o_upd_drop), int'(e_drop));
      chk("W0_re",    int'(o_W0_re),    e_w[0]);
      chk("W0_im",    int'(o_W0_im),    e_w[1]);
      chk("W1_re",    int'(o_W1_re),    e_w[2]);
      chk("W1_im",    int'(o_W1_im),    e_w[3]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_edge();
    chk_en = 1'b1;
    #1;
  endtask

  task automatic idle();
    i_rd_en = 0; i_upd_valid = 0; i_clear = 0;
    i_G0_re = 0; i_G0_im = 0; i_G1_re = 0; i_G1_im = 0;
  endtask

  task automatic rd(input int k);
    idle(); i_rd_en = 1; i_k_idx = 5'(k);
    cyc();
    idle();
  endtask

  task automatic wait_sweep(input string name, output int n);
    n = 0;
    while (o_busy && n < 100) begin cyc(); n++; end
    if (n >= 100) chk(name, int'(o_busy), 0);
  endtask

  initial begin
    int n;
    // Reset and initial sweep
    rst = 0; cyc(); cyc();
    chk("lit_rst_busy", int'(o_busy), 1);
    chk("lit_rst_valid", int'(o_rd_valid), 0);
    rst = 1;
    wait_sweep("sweep_timeout", n);
    chk("lit_sweep_cycles", n, 32);

    // All bins read zero, valid one cycle after request
    for (int k = 0; k < 32; k++) begin
      rd(k);
      chk("lit_init_valid", int'(o_rd_valid), 1);
      chk("lit_init_zero", int'(o_W0_re) | int'(o_W1_im), 0);
    end
    cyc();  // rd_en low: valid drops, outputs hold

    // Single update: -(-160 >>> 4) = +10
    i_upd_valid = 1; i_upd_k = 5; i_G0_re = -160; cyc(); idle();
    rd(5);
    chk("lit_k5_W0_re", int'(o_W0_re), 10);
    chk("lit_k5_W0_im", int'(o_W0_im), 0);
    chk("lit_k5_W1_re", int'(o_W1_re), 0);
    chk("lit_k5_W1_im", int'(o_W1_im), 0);

    // Positive saturation: +2048 per step, 20 back-to-back steps
    for (int i = 0; i < 20; i++) begin
      i_upd_valid = 1; i_upd_k = 7; i_G0_re = -32768; cyc();
    end
    idle(); rd(7);
    chk("lit_k7_sat_pos", int'(o_W0_re), 32767);

    // Negative saturation: -2047 per step
    for (int i = 0; i < 20; i++) begin
      i_upd_valid = 1; i_upd_k = 9; i_G0_im = 32767; cyc();
    end
    idle(); rd(9);
    chk("lit_k9_sat_neg", int'(o_W0_im), -32768);

    // Read-before-write on same bin
    idle(); i_rd_en = 1; i_k_idx = 3; i_upd_valid = 1; i_upd_k = 3; i_G1_im = 64;
    cyc(); idle();
    chk("lit_rbw_old", int'(o_W1_im), 0);
    rd(3);
    chk("lit_rbw_new", int'(o_W1_im), -4);

    // Back-to-back accumulation: +3 twice
    for (int i = 0; i < 2; i++) begin
      i_upd_valid = 1; i_upd_k = 12; i_G1_re = -48; cyc();
    end
    idle(); rd(12);
    chk("lit_accum", int'(o_W1_re), 6);

    // Update coincident with clear is dropped; updates/reads in CLEAR too
    i_upd_valid = 1; i_upd_k = 5; i_G0_re = -160; i_clear = 1; cyc(); idle();
    chk("lit_drop_clr", int'(o_upd_drop), 1);
    chk("lit_busy_clr", int'(o_busy), 1);
    i_upd_valid = 1; i_upd_k = 6; i_G0_re = -160; i_rd_en = 1; i_k_idx = 6; cyc(); idle();
    chk("lit_drop_in_clear", int'(o_upd_drop), 1);
    chk("lit_rd_in_clear", int'(o_rd_valid), 0);
    wait_sweep("clr_timeout", n);
    chk("lit_clr_sweep_cycles", n + 1, 32);
    for (int k = 0; k < 32; k++) begin
      rd(k);
      chk("lit_post_clr_zero", int'(o_W0_re) | int'(o_W0_im) | int'(o_W1_re) | int'(o_W1_im), 0);
    end

    // Reset at cycle 10 of a sweep restarts a full sweep
    i_clear = 1; cyc(); idle();
    repeat (10) cyc();
    rst = 0; cyc(); rst = 1;
    wait_sweep("rst_mid_timeout", n);
    chk("lit_rst_mid_sweep", n, 32);

    // Reset mid-RUN wipes contents
    i_upd_valid = 1; i_upd_k = 1; i_G1_re = 320; cyc(); idle();
    rd(1);
    chk("lit_k1_before_rst", int'(o_W1_re), -20);
    rst = 0; cyc();
    chk("lit_rst_W_zero", int'(o_W1_re), 0);
    rst = 1;
    wait_sweep("rst_run_timeout", n);
    rd(1);
    chk("lit_k1_after_rst", int'(o_W1_re), 0);
    cyc();

    @(posedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
